// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter between N_REQ byte producers.
// Optional watchdog on a stuck frame is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter  int N_REQ       = 4,
    parameter  int TIMEOUT_CYC = 200000,
    localparam int GID_W       = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic                 srst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_en,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic [GID_W-1:0]     grant_id,
    output logic                 active,
    output logic [15:0]          sent_cnt,
    output logic                 timeout_err
);

    localparam int SUM_W = GID_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("uart_tx_arbiter: illegal N_REQ or TIMEOUT_CYC");
    end

    state_t             state_q,     state_d;
    logic [GID_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [7:0]         tx_data_q,   tx_data_d;
    logic               tx_en_q,     tx_en_d;
    logic [N_REQ-1:0]   req_ready_q, req_ready_d;
    logic [GID_W-1:0]   grant_id_q,  grant_id_d;
    logic               active_q,    active_d;
    logic [15:0]        sent_cnt_q,  sent_cnt_d;

    logic               grant_vld_s;
    logic [GID_W-1:0]   grant_idx_s;
    logic [GID_W-1:0]   grant_nxt_s;
    logic               wd_expired_s;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int            WD_W    = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0]    wd_cnt_q,      wd_cnt_d;
    logic               timeout_err_q, timeout_err_d;

    // Watchdog: restarts on every grant, counts WAIT cycles, latches a sticky error on expiry.
    always_comb begin
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = timeout_err_q;
        wd_expired_s  = 1'b0;
        if (state_q == ST_IDLE) begin
            wd_cnt_d = '0;
        end else if (tx_done) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q == WD_LAST) begin
            wd_expired_s  = 1'b1;
            timeout_err_d = 1'b1;
            wd_cnt_d      = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + {{(WD_W-1){1'b0}}, 1'b1};
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else if (srst) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign wd_expired_s = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    // Round-robin search: first valid requester at or above rr_ptr, wrapping to 0.
    always_comb begin
        logic [SUM_W-1:0] idx;
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        idx         = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, rr_ptr_q} + SUM_W'(i);
            if (idx >= SUM_W'(N_REQ)) begin
                idx = idx - SUM_W'(N_REQ);
            end else begin
                idx = idx;
            end
            if (!grant_vld_s && req_valid[idx[GID_W-1:0]]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = idx[GID_W-1:0];
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
        if (grant_idx_s == GID_W'(N_REQ - 1)) begin
            grant_nxt_s = '0;
        end else begin
            grant_nxt_s = grant_idx_s + {{(GID_W-1){1'b0}}, 1'b1};
        end
    end

    // Next-state and output logic; tx_en / req_ready default low so they pulse for one cycle.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        tx_data_d   = tx_data_q;
        tx_en_d     = 1'b0;
        req_ready_d = '0;
        grant_id_d  = grant_id_q;
        active_d    = active_q;
        sent_cnt_d  = sent_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld_s && !tx_busy) begin
                    tx_data_d   = req_data[{grant_idx_s, 3'b000} +: 8];
                    grant_id_d  = grant_idx_s;
                    req_ready_d = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
                    tx_en_d     = 1'b1;
                    active_d    = 1'b1;
                    rr_ptr_d    = grant_nxt_s;
                    state_d     = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (tx_done) begin
                    state_d    = ST_IDLE;
                    active_d   = 1'b0;
                    sent_cnt_d = sent_cnt_q + 16'd1;
                end else if (wd_expired_s) begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    // Main state and output registers.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            tx_data_q   <= 8'h00;
            tx_en_q     <= 1'b0;
            req_ready_q <= '0;
            grant_id_q  <= '0;
            active_q    <= 1'b0;
            sent_cnt_q  <= 16'd0;
        end else if (srst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            tx_data_q   <= 8'h00;
            tx_en_q     <= 1'b0;
            req_ready_q <= '0;
            grant_id_q  <= '0;
            active_q    <= 1'b0;
            sent_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            tx_data_q   <= tx_data_d;
            tx_en_q     <= tx_en_d;
            req_ready_q <= req_ready_d;
            grant_id_q  <= grant_id_d;
            active_q    <= active_d;
            sent_cnt_q  <= sent_cnt_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_en     = tx_en_q;
    assign req_ready = req_ready_q;
    assign grant_id  = grant_id_q;
    assign active    = active_q;
    assign sent_cnt  = sent_cnt_q;

endmodule
